// File: rtl/axil_xbar_pkg.sv
// Shared definitions for the AXI-Lite write crossbar.
//   xbar_state_t : transaction FSM states (IDLE -> ADDR -> RESP)
//   RESP_OKAY / RESP_DECERR : write response codes
//   idx_width()  : index width for an N-entry selector (never below 1 bit)
package axil_xbar_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_RESP = 2'd2
   } xbar_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axil_rr_arbiter.sv
// Round-robin arbiter. The search starts at the master after the one that
// most recently completed a transaction, so every requester is served within
// N grants.
//   clk, reset   : clock, synchronous active-high reset
//   req          : request vector, one bit per master
//   advance      : pulse when the granted transaction completes
//   done_idx     : index of the master whose transaction completed
//   grant        : combinational winner index (valid when grant_valid)
//   grant_valid  : at least one request is present
module axil_rr_arbiter
   import axil_xbar_pkg::*;
#(
   parameter int N = 4,
   parameter int IW = idx_width(N)
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          advance,
   input  logic [IW-1:0] done_idx,
   output logic [IW-1:0] grant,
   output logic          grant_valid
);

   logic [IW-1:0] last_r;
   logic [IW-1:0] cand_s;
   logic          hit_s;
   logic          found_s;

   // Remember the last completed master; reset makes master 0 the first winner.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_r <= IW'(N - 1);
      end else if (advance) begin
         last_r <= done_idx;
      end else begin
         last_r <= last_r;
      end
   end

   // Rotating-priority search: first requester at or after last_r+1 (mod N).
   always_comb begin
      grant   = last_r;
      found_s = 1'b0;
      cand_s  = last_r;
      hit_s   = 1'b0;
      for (int i = 0; i < N; i++) begin
         cand_s  = IW'((int'(last_r) + 1 + i) % N);
         hit_s   = req[cand_s] & ~found_s;
         grant   = hit_s ? cand_s : grant;
         found_s = found_s | hit_s;
      end
   end

   assign grant_valid = |req;

endmodule

// File: rtl/axil_write_xbar.sv
// Shared-path AXI-Lite write interconnect: NUMBER_MASTER masters to
// NUMBER_SLAVE slaves, one write in flight. Unmapped addresses go to an
// internal default slave that completes AW/W and answers DECERR.
//   aclk, areset            : clock, synchronous active-high reset
//   m_axil_aw*/w*/b*        : master-side ports, flattened per master
//   s_axil_aw*/w*/b*        : slave-side ports, flattened per slave
// Payload buses toward slaves broadcast the granted master's AW/W content.
module axil_write_xbar
   import axil_xbar_pkg::*;
#(
   parameter int NUMBER_MASTER  = 4,
   parameter int NUMBER_SLAVE   = 4,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter logic [NUMBER_SLAVE*AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET =
      {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000},
   parameter logic [NUMBER_SLAVE*AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE =
      {32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF}
)
(
   input  logic                                         aclk,
   input  logic                                         areset,
   // master side
   input  logic [NUMBER_MASTER*AXI_ADDR_WIDTH-1:0]      m_axil_awaddr,
   input  logic [NUMBER_MASTER-1:0]                     m_axil_awvalid,
   output logic [NUMBER_MASTER-1:0]                     m_axil_awready,
   input  logic [NUMBER_MASTER*AXI_DATA_WIDTH-1:0]      m_axil_wdata,
   input  logic [NUMBER_MASTER*(AXI_DATA_WIDTH/8)-1:0]  m_axil_wstrb,
   input  logic [NUMBER_MASTER-1:0]                     m_axil_wvalid,
   output logic [NUMBER_MASTER-1:0]                     m_axil_wready,
   output logic [NUMBER_MASTER*2-1:0]                   m_axil_bresp,
   output logic [NUMBER_MASTER-1:0]                     m_axil_bvalid,
   input  logic [NUMBER_MASTER-1:0]                     m_axil_bready,
   // slave side
   output logic [NUMBER_SLAVE*AXI_ADDR_WIDTH-1:0]       s_axil_awaddr,
   output logic [NUMBER_SLAVE-1:0]                      s_axil_awvalid,
   input  logic [NUMBER_SLAVE-1:0]                      s_axil_awready,
   output logic [NUMBER_SLAVE*AXI_DATA_WIDTH-1:0]       s_axil_wdata,
   output logic [NUMBER_SLAVE*(AXI_DATA_WIDTH/8)-1:0]   s_axil_wstrb,
   output logic [NUMBER_SLAVE-1:0]                      s_axil_wvalid,
   input  logic [NUMBER_SLAVE-1:0]                      s_axil_wready,
   input  logic [NUMBER_SLAVE*2-1:0]                    s_axil_bresp,
   input  logic [NUMBER_SLAVE-1:0]                      s_axil_bvalid,
   output logic [NUMBER_SLAVE-1:0]                      s_axil_bready
);

   localparam int AW = AXI_ADDR_WIDTH;
   localparam int DW = AXI_DATA_WIDTH;
   localparam int SW = AXI_DATA_WIDTH / 8;
   localparam int MW = idx_width(NUMBER_MASTER);
   // one extra target code for the internal default slave
   localparam int TW = idx_width(NUMBER_SLAVE + 1);
   localparam logic [TW-1:0] DEC_IDX = TW'(NUMBER_SLAVE);

   xbar_state_t   state_r, state_s;
   logic [MW-1:0] grant_r, grant_s;
   logic [TW-1:0] target_r, target_s;
   logic          aw_done_r, aw_done_s;
   logic          w_done_r, w_done_s;

   logic [MW-1:0] arb_grant_s;
   logic          arb_valid_s;
   logic [AW-1:0] dec_addr_s;
   logic [TW-1:0] dec_target_s;
   logic          slave_hit_s;

   logic [AW-1:0] sel_awaddr_s;
   logic [DW-1:0] sel_wdata_s;
   logic [SW-1:0] sel_wstrb_s;
   logic          sel_awvalid_s, sel_wvalid_s, sel_bready_s;

   logic          is_dec_s, tgt_sel_s;
   logic          tgt_awready_s, tgt_wready_s, tgt_bvalid_s;
   logic [1:0]    tgt_bresp_s;
   logic          in_addr_s, in_resp_s;
   logic          aw_hs_s, w_hs_s, b_hs_s;

   axil_rr_arbiter #(.N(NUMBER_MASTER), .IW(MW)) u_arb (
      .clk         (aclk),
      .reset       (areset),
      .req         (m_axil_awvalid),
      .advance     (b_hs_s),
      .done_idx    (grant_r),
      .grant       (arb_grant_s),
      .grant_valid (arb_valid_s)
   );

   assign dec_addr_s = m_axil_awaddr[int'(arb_grant_s)*AW +: AW];

   // Address decode of the arbitration winner; descending loop lets the lowest index win.
   always_comb begin
      dec_target_s = DEC_IDX;
      slave_hit_s  = 1'b0;
      for (int j = NUMBER_SLAVE - 1; j >= 0; j--) begin
         slave_hit_s  = (dec_addr_s & ~AXI_ADDR_RANGE[j*AW +: AW]) == AXI_ADDR_OFFSET[j*AW +: AW];
         dec_target_s = slave_hit_s ? TW'(j) : dec_target_s;
      end
   end

   assign sel_awaddr_s  = m_axil_awaddr[int'(grant_r)*AW +: AW];
   assign sel_wdata_s   = m_axil_wdata[int'(grant_r)*DW +: DW];
   assign sel_wstrb_s   = m_axil_wstrb[int'(grant_r)*SW +: SW];
   assign sel_awvalid_s = m_axil_awvalid[grant_r];
   assign sel_wvalid_s  = m_axil_wvalid[grant_r];
   assign sel_bready_s  = m_axil_bready[grant_r];

   assign in_addr_s = (state_r == ST_ADDR);
   assign in_resp_s = (state_r == ST_RESP);
   assign is_dec_s  = (target_r == DEC_IDX);

   // Collect the target's ready/response; the default slave is always ready and answers DECERR.
   always_comb begin
      tgt_awready_s = 1'b0;
      tgt_wready_s  = 1'b0;
      tgt_bvalid_s  = 1'b0;
      tgt_bresp_s   = RESP_OKAY;
      tgt_sel_s     = 1'b0;
      for (int j = 0; j < NUMBER_SLAVE; j++) begin
         tgt_sel_s     = (target_r == TW'(j));
         tgt_awready_s = tgt_awready_s | (tgt_sel_s & s_axil_awready[j]);
         tgt_wready_s  = tgt_wready_s  | (tgt_sel_s & s_axil_wready[j]);
         tgt_bvalid_s  = tgt_bvalid_s  | (tgt_sel_s & s_axil_bvalid[j]);
         tgt_bresp_s   = tgt_bresp_s   | ({2{tgt_sel_s}} & s_axil_bresp[j*2 +: 2]);
      end
      tgt_awready_s = tgt_awready_s | is_dec_s;
      tgt_wready_s  = tgt_wready_s  | is_dec_s;
      tgt_bvalid_s  = tgt_bvalid_s  | is_dec_s;
      tgt_bresp_s   = is_dec_s ? RESP_DECERR : tgt_bresp_s;
   end

   // Done flags mask each channel after its single handshake.
   assign aw_hs_s = in_addr_s & sel_awvalid_s & ~aw_done_r & tgt_awready_s;
   assign w_hs_s  = in_addr_s & sel_wvalid_s  & ~w_done_r  & tgt_wready_s;
   assign b_hs_s  = in_resp_s & tgt_bvalid_s & sel_bready_s;

   // Next-state: grant/target captured in IDLE, AW and W tracked independently in ADDR.
   always_comb begin
      state_s   = state_r;
      grant_s   = grant_r;
      target_s  = target_r;
      aw_done_s = aw_done_r;
      w_done_s  = w_done_r;
      case (state_r)
         ST_IDLE: begin
            if (arb_valid_s) begin
               state_s  = ST_ADDR;
               grant_s  = arb_grant_s;
               target_s = dec_target_s;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_ADDR: begin
            aw_done_s = aw_done_r | aw_hs_s;
            w_done_s  = w_done_r | w_hs_s;
            if (aw_done_s && w_done_s) begin
               state_s = ST_RESP;
            end else begin
               state_s = ST_ADDR;
            end
         end
         ST_RESP: begin
            if (b_hs_s) begin
               state_s   = ST_IDLE;
               aw_done_s = 1'b0;
               w_done_s  = 1'b0;
            end else begin
               state_s   = ST_RESP;
            end
         end
         default: begin
            state_s   = ST_IDLE;
            aw_done_s = 1'b0;
            w_done_s  = 1'b0;
         end
      endcase
   end

   // State and transaction context registers.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_r   <= ST_IDLE;
         grant_r   <= {MW{1'b0}};
         target_r  <= {TW{1'b0}};
         aw_done_r <= 1'b0;
         w_done_r  <= 1'b0;
      end else begin
         state_r   <= state_s;
         grant_r   <= grant_s;
         target_r  <= target_s;
         aw_done_r <= aw_done_s;
         w_done_r  <= w_done_s;
      end
   end

   // Master-side returns go only to the granted master; others see zero.
   always_comb begin
      m_axil_awready = {NUMBER_MASTER{1'b0}};
      m_axil_wready  = {NUMBER_MASTER{1'b0}};
      m_axil_bvalid  = {NUMBER_MASTER{1'b0}};
      m_axil_bresp   = {(NUMBER_MASTER*2){1'b0}};
      for (int i = 0; i < NUMBER_MASTER; i++) begin
         m_axil_awready[i]      = in_addr_s & (grant_r == MW'(i)) & ~aw_done_r & tgt_awready_s;
         m_axil_wready[i]       = in_addr_s & (grant_r == MW'(i)) & ~w_done_r & tgt_wready_s;
         m_axil_bvalid[i]       = in_resp_s & (grant_r == MW'(i)) & tgt_bvalid_s;
         m_axil_bresp[i*2 +: 2] = {2{in_resp_s & (grant_r == MW'(i))}} & tgt_bresp_s;
      end
   end

   // Slave-side valids/bready go only to the registered target.
   always_comb begin
      s_axil_awvalid = {NUMBER_SLAVE{1'b0}};
      s_axil_wvalid  = {NUMBER_SLAVE{1'b0}};
      s_axil_bready  = {NUMBER_SLAVE{1'b0}};
      for (int j = 0; j < NUMBER_SLAVE; j++) begin
         s_axil_awvalid[j] = in_addr_s & (target_r == TW'(j)) & sel_awvalid_s & ~aw_done_r;
         s_axil_wvalid[j]  = in_addr_s & (target_r == TW'(j)) & sel_wvalid_s & ~w_done_r;
         s_axil_bready[j]  = in_resp_s & (target_r == TW'(j)) & sel_bready_s;
      end
   end

   assign s_axil_awaddr = {NUMBER_SLAVE{sel_awaddr_s}};
   assign s_axil_wdata  = {NUMBER_SLAVE{sel_wdata_s}};
   assign s_axil_wstrb  = {NUMBER_SLAVE{sel_wstrb_s}};

endmodule

// File: tb/tb_axil_write_xbar.sv
// Directed self-checking bench for axil_write_xbar (4 masters, 4 slaves).
// Slave models acknowledge AW/W and answer once both have arrived; slave 3
// answers SLVERR so response routing is visible.
`timescale 1ns/1ps
module tb_axil_write_xbar;

   localparam int NM = 4;
   localparam int NS = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SB = DW / 8;

   logic aclk = 1'b0;
   logic areset;
   always #5 aclk = ~aclk;

   logic [NM*AW-1:0] m_awaddr;
   logic [NM-1:0]    m_awvalid, m_awready;
   logic [NM*DW-1:0] m_wdata;
   logic [NM*SB-1:0] m_wstrb;
   logic [NM-1:0]    m_wvalid, m_wready;
   logic [NM*2-1:0]  m_bresp;
   logic [NM-1:0]    m_bvalid, m_bready;

   logic [NS*AW-1:0] s_awaddr;
   logic [NS-1:0]    s_awvalid, s_awready;
   logic [NS*DW-1:0] s_wdata;
   logic [NS*SB-1:0] s_wstrb;
   logic [NS-1:0]    s_wvalid, s_wready;
   logic [NS*2-1:0]  s_bresp;
   logic [NS-1:0]    s_bvalid, s_bready;

   axil_write_xbar #(
      .NUMBER_MASTER(NM), .NUMBER_SLAVE(NS), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)
   ) dut (
      .aclk(aclk), .areset(areset),
      .m_axil_awaddr(m_awaddr), .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready),
      .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(m_wvalid),
      .m_axil_wready(m_wready), .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid),
      .m_axil_bready(m_bready),
      .s_axil_awaddr(s_awaddr), .s_axil_awvalid(s_awvalid), .s_axil_awready(s_awready),
      .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb), .s_axil_wvalid(s_wvalid),
      .s_axil_wready(s_wready), .s_axil_bresp(s_bresp), .s_axil_bvalid(s_bvalid),
      .s_axil_bready(s_bready)
   );

   // ---------------- slave models ----------------
   logic [NS-1:0] s_aw_got, s_w_got;
   logic [AW-1:0] cap_addr [NS];
   logic [DW-1:0] cap_data [NS];
   logic [SB-1:0] cap_strb [NS];
   int            aw_cnt [NS];
   int            w_cnt [NS];

   assign s_bvalid = s_aw_got & s_w_got;
   assign s_bresp  = {2'b10, 2'b00, 2'b00, 2'b00};

   // Capture slave-side handshakes and release the response on B handshake.
   always @(posedge aclk) begin
      if (areset) begin
         s_aw_got <= '0;
         s_w_got  <= '0;
      end else begin
         for (int j = 0; j < NS; j++) begin
            if (s_awvalid[j] && s_awready[j]) begin
               s_aw_got[j] <= 1'b1;
               aw_cnt[j]   <= aw_cnt[j] + 1;
               cap_addr[j] <= s_awaddr[j*AW +: AW];
            end
            if (s_wvalid[j] && s_wready[j]) begin
               s_w_got[j]  <= 1'b1;
               w_cnt[j]    <= w_cnt[j] + 1;
               cap_data[j] <= s_wdata[j*DW +: DW];
               cap_strb[j] <= s_wstrb[j*SB +: SB];
            end
            if (s_bvalid[j] && s_bready[j]) begin
               s_aw_got[j] <= 1'b0;
               s_w_got[j]  <= 1'b0;
            end
         end
      end
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_err = 0;
   int grant_q[$];
   int s_valid_samples = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // One master write, called at a negedge. Latencies are in cycles from the call.
   task automatic master_write(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [SB-1:0] strb, input int aw_delay, input int bready_delay,
                               output int aw_lat, output int w_lat, output int b_lat,
                               output int held, output logic [1:0] resp);
      int t;
      bit aw_pend, w_pend, b_pend;
      m_awaddr[m*AW +: AW] = addr;
      m_wdata[m*DW +: DW]  = data;
      m_wstrb[m*SB +: SB]  = strb;
      m_wvalid[m]  = 1'b1;
      m_awvalid[m] = (aw_delay == 0);
      m_bready[m]  = (bready_delay == 0);
      aw_pend = 1'b1; w_pend = 1'b1; b_pend = 1'b1;
      aw_lat = -1; w_lat = -1; b_lat = -1; held = 0; resp = 2'b01;
      t = 0;
      while (b_pend && t < 200) begin
         #1;
         s_valid_samples += int'(|s_awvalid) + int'(|s_wvalid);
         if (aw_pend && m_awvalid[m] && m_awready[m]) begin
            aw_pend = 1'b0; aw_lat = t; grant_q.push_back(m);
         end
         if (w_pend && m_wvalid[m] && m_wready[m]) begin
            w_pend = 1'b0; w_lat = t;
         end
         if (m_bvalid[m]) begin
            if (b_lat < 0) b_lat = t;
            if (m_bready[m]) begin
               b_pend = 1'b0; resp = m_bresp[m*2 +: 2];
            end else begin
               held++;
            end
         end
         @(negedge aclk);
         t++;
         if (!aw_pend) m_awvalid[m] = 1'b0;
         else if (t == aw_delay) m_awvalid[m] = 1'b1;
         if (!w_pend) m_wvalid[m] = 1'b0;
         if (held >= bready_delay) m_bready[m] = 1'b1;
      end
      m_bready[m]  = 1'b0;
      m_awvalid[m] = 1'b0;
      m_wvalid[m]  = 1'b0;
      check_eq($sformatf("m%0d_timeout", m), 64'(b_pend), 64'd0);
   endtask

   int la [NM], lw [NM], lb [NM], lh [NM];
   logic [1:0] lr [NM];
   int cnt0_aw, cnt0_w, tot_aw, stall_k;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      areset = 1'b1;
      m_awaddr = '0; m_awvalid = '0; m_wdata = '0; m_wstrb = '0; m_wvalid = '0; m_bready = '0;
      s_awready = '1; s_wready = '1;
      for (int j = 0; j < NS; j++) begin
         aw_cnt[j] = 0; w_cnt[j] = 0;
      end
      repeat (3) @(negedge aclk);
      #1;
      check_eq("rst_m_awready", 64'(m_awready), 64'd0);
      check_eq("rst_m_wready", 64'(m_wready), 64'd0);
      check_eq("rst_m_bvalid", 64'(m_bvalid), 64'd0);
      check_eq("rst_m_bresp", 64'(m_bresp), 64'd0);
      check_eq("rst_s_valid", 64'({s_awvalid, s_wvalid, s_bready}), 64'd0);
      @(negedge aclk);
      areset = 1'b0;

      // single write M0 -> S0
      master_write(0, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, la[0], lw[0], lb[0], lh[0], lr[0]);
      check_eq("single_aw_lat", 64'(la[0]), 64'd1);
      check_eq("single_b_lat", 64'(lb[0]), 64'd2);
      check_eq("single_resp", 64'(lr[0]), 64'd0);
      check_eq("single_addr", 64'(cap_addr[0]), 64'h1000_0004);
      check_eq("single_data", 64'(cap_data[0]), 64'hDEAD_BEEF);
      check_eq("single_strb", 64'(cap_strb[0]), 64'hF);
      check_eq("single_aw_cnt", 64'(aw_cnt[0]), 64'd1);

      // fresh reset, then all four masters to S1
      areset = 1'b1;
      @(negedge aclk);
      areset = 1'b0;
      grant_q.delete();
      fork
         master_write(0, 32'h2000_0010, 32'h0000_00A0, 4'hF, 0, 0, la[0], lw[0], lb[0], lh[0], lr[0]);
         master_write(1, 32'h2000_0014, 32'h0000_00A1, 4'hF, 0, 0, la[1], lw[1], lb[1], lh[1], lr[1]);
         master_write(2, 32'h2000_0018, 32'h0000_00A2, 4'hF, 0, 0, la[2], lw[2], lb[2], lh[2], lr[2]);
         master_write(3, 32'h2000_001C, 32'h0000_00A3, 4'hF, 0, 0, la[3], lw[3], lb[3], lh[3], lr[3]);
      join
      check_eq("rr_count", 64'(grant_q.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("rr_order_%0d", i), 64'((grant_q.size() > i) ? grant_q[i] : -1), 64'(i));
      end
      check_eq("rr_m3_aw_lat", 64'(la[3]), 64'd10);
      check_eq("rr_s1_aw_cnt", 64'(aw_cnt[1]), 64'd4);
      check_eq("rr_s1_last_data", 64'(cap_data[1]), 64'h0000_00A3);
      check_eq("rr_m3_resp", 64'(lr[3]), 64'd0);

      // after last grant 3: M0 is served before M2
      grant_q.delete();
      fork
         master_write(2, 32'h2000_0020, 32'h0000_00B2, 4'h3, 0, 0, la[2], lw[2], lb[2], lh[2], lr[2]);
         master_write(0, 32'h2000_0024, 32'h0000_00B0, 4'hC, 0, 0, la[0], lw[0], lb[0], lh[0], lr[0]);
      join
      check_eq("rr2_first", 64'((grant_q.size() > 0) ? grant_q[0] : -1), 64'd0);
      check_eq("rr2_second", 64'((grant_q.size() > 1) ? grant_q[1] : -1), 64'd2);
      check_eq("rr2_s1_strb", 64'(cap_strb[1]), 64'h3);

      // unmapped address -> default slave
      tot_aw = aw_cnt[0] + aw_cnt[1] + aw_cnt[2] + aw_cnt[3];
      s_valid_samples = 0;
      master_write(1, 32'h5000_0000, 32'h1111_2222, 4'hF, 0, 0, la[1], lw[1], lb[1], lh[1], lr[1]);
      check_eq("dec_resp", 64'(lr[1]), 64'h3);
      check_eq("dec_no_slave_valid", 64'(s_valid_samples), 64'd0);
      check_eq("dec_aw_lat", 64'(la[1]), 64'd1);
      check_eq("dec_b_lat", 64'(lb[1]), 64'd2);
      check_eq("dec_slave_cnt", 64'(aw_cnt[0] + aw_cnt[1] + aw_cnt[2] + aw_cnt[3]), 64'(tot_aw));

      // W four cycles ahead of AW, slave awready stalled five cycles
      cnt0_aw = aw_cnt[0];
      cnt0_w  = w_cnt[0];
      s_awready[0] = 1'b0;
      fork
         master_write(3, 32'h1000_0100, 32'h1234_5678, 4'b0101, 4, 0, la[3], lw[3], lb[3], lh[3], lr[3]);
         begin
            stall_k = 0;
            #1;
            while (!s_awvalid[0] && stall_k < 50) begin
               @(negedge aclk);
               #1;
               stall_k++;
            end
            repeat (5) @(negedge aclk);
            s_awready[0] = 1'b1;
         end
      join
      check_eq("stall_seen", 64'(stall_k < 50), 64'd1);
      check_eq("wfirst_w_lat", 64'(lw[3]), 64'd5);
      check_eq("wfirst_aw_lat", 64'(la[3]), 64'd10);
      check_eq("wfirst_b_lat", 64'(lb[3]), 64'd11);
      check_eq("wfirst_aw_cnt", 64'(aw_cnt[0] - cnt0_aw), 64'd1);
      check_eq("wfirst_w_cnt", 64'(w_cnt[0] - cnt0_w), 64'd1);
      check_eq("wfirst_strb", 64'(cap_strb[0]), 64'h5);

      // M0 holds bready low six cycles; M1 must wait for the next grant
      fork
         master_write(0, 32'h3000_0000, 32'h0BAD_F00D, 4'hF, 0, 6, la[0], lw[0], lb[0], lh[0], lr[0]);
         master_write(1, 32'h4000_0008, 32'hCAFE_0001, 4'b1100, 0, 0, la[1], lw[1], lb[1], lh[1], lr[1]);
      join
      check_eq("hold_b_lat", 64'(lb[0]), 64'd2);
      check_eq("hold_cycles", 64'(lh[0]), 64'd6);
      check_eq("hold_resp", 64'(lr[0]), 64'd0);
      check_eq("hold_next_grant", 64'(la[1]), 64'd10);
      check_eq("hold_m1_resp", 64'(lr[1]), 64'h2);
      check_eq("hold_s2_addr", 64'(cap_addr[2]), 64'h3000_0000);
      check_eq("hold_s3_data", 64'(cap_data[3]), 64'hCAFE_0001);
      check_eq("hold_s3_strb", 64'(cap_strb[3]), 64'hC);

      // reset in the middle of ADDR
      cnt0_aw = aw_cnt[0];
      s_awready[0] = 1'b0;
      s_wready[0]  = 1'b0;
      m_awaddr[2*AW +: AW] = 32'h1000_0040;
      m_wdata[2*DW +: DW]  = 32'h7777_8888;
      m_awvalid[2] = 1'b1;
      m_wvalid[2]  = 1'b1;
      @(negedge aclk);
      #1;
      check_eq("mid_addr_awvalid", 64'(s_awvalid), 64'h1);
      check_eq("mid_addr_wvalid", 64'(s_wvalid), 64'h1);
      @(negedge aclk);
      areset = 1'b1;
      @(negedge aclk);
      #1;
      check_eq("rst2_m_ready", 64'({m_awready, m_wready}), 64'd0);
      check_eq("rst2_m_b", 64'({m_bvalid, m_bresp}), 64'd0);
      check_eq("rst2_s_out", 64'({s_awvalid, s_wvalid, s_bready}), 64'd0);
      check_eq("rst2_no_hs", 64'(aw_cnt[0]), 64'(cnt0_aw));
      @(negedge aclk);
      m_awvalid[2] = 1'b0;
      m_wvalid[2]  = 1'b0;
      s_awready[0] = 1'b1;
      s_wready[0]  = 1'b1;
      areset = 1'b0;
      master_write(1, 32'h1000_0020, 32'h5555_AAAA, 4'hF, 0, 0, la[1], lw[1], lb[1], lh[1], lr[1]);
      check_eq("post_rst_aw_lat", 64'(la[1]), 64'd1);
      check_eq("post_rst_resp", 64'(lr[1]), 64'd0);
      check_eq("post_rst_addr", 64'(cap_addr[0]), 64'h1000_0020);
      check_eq("post_rst_data", 64'(cap_data[0]), 64'h5555_AAAA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axil_write_xbar.md
# axil_write_xbar

Shared-path AXI-Lite write interconnect connecting NUMBER_MASTER masters to NUMBER_SLAVE slaves, one write transaction in flight at a time. Successor to the current write interconnect: data width fully parametrised, fair round-robin arbitration, mask-based address decode, and an internal default slave that answers unmapped writes with DECERR instead of hanging. Sits between CPU/DMA masters and peripheral register banks.

## Interface
- NUMBER_MASTER, 4, master port count (1..16)
- NUMBER_SLAVE, 4, slave port count (1..16)
- AXI_DATA_WIDTH, 32, wdata width; multiple of 8
- AXI_ADDR_WIDTH, 32, address width
- AXI_ADDR_OFFSET[NUMBER_SLAVE], {1000_0000,2000_0000,3000_0000,4000_0000}, slave base addresses
- AXI_ADDR_RANGE[NUMBER_SLAVE], {0000_FFFF x4}, slave address mask (ones = offset bits within slave)

Clocking: one clock; reset is synchronous and active-high.
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- m_axil_awaddr  in  AXI_ADDR_WIDTH x NUMBER_MASTER  master write address
- m_axil_awvalid / m_axil_awready  in / out  NUMBER_MASTER  AW handshake
- m_axil_wdata  in  AXI_DATA_WIDTH x NUMBER_MASTER  write data
- m_axil_wstrb  in  AXI_DATA_WIDTH/8 x NUMBER_MASTER  byte strobes
- m_axil_wvalid / m_axil_wready  in / out  NUMBER_MASTER  W handshake
- m_axil_bresp  out  2 x NUMBER_MASTER  write response
- m_axil_bvalid / m_axil_bready  out / in  NUMBER_MASTER  B handshake
- s_axil_awaddr, s_axil_awvalid/awready, s_axil_wdata, s_axil_wstrb, s_axil_wvalid/wready, s_axil_bresp, s_axil_bvalid/bready: mirror of master side, indexed by NUMBER_SLAVE, directions reversed

## Operation
- Decode: slave i hits when (awaddr & ~RANGE[i]) == OFFSET[i]; lowest index wins on overlap; no hit selects the default slave (DEC).
- FSM states IDLE, ADDR, RESP.
- IDLE: request vector = m_axil_awvalid. If nonzero, round-robin grant starting at (last_grant+1) mod NUMBER_MASTER; register grant index and decoded target; go ADDR. W-only masters wait.
- ADDR: granted master's AW and W routed to target; s_awvalid = m_awvalid & ~aw_done, s_wvalid = m_wvalid & ~w_done; readies returned combinationally. aw_done/w_done set on respective handshakes; AW and W complete in any order or same cycle. Both done -> RESP. Target DEC: awready/wready asserted internally for one handshake each.
- RESP: target's bvalid/bresp routed to granted master, master bready routed to target. DEC drives bvalid=1, bresp=2'b11. On bvalid&bready: update last_grant, clear done flags, go IDLE.
- All non-granted master readies and bvalid are 0; all non-targeted slave valids and bready are 0; slave awaddr/wdata/wstrb buses broadcast the granted master's payload (don't-care when valid low).
- Reset: state IDLE, last_grant = NUMBER_MASTER-1 (master 0 first), done flags 0; all valid/ready/bvalid outputs 0, bresp 0. Reset mid-transaction abandons it; slave-side handshakes are not completed.

## Timing
- Grant registered: awvalid seen in IDLE at cycle 0 -> s_awvalid earliest cycle 1.
- Zero-wait slave: AW+W at cycle 1, RESP at cycle 2, master bvalid cycle 2 if slave bvalid ready; next grant IDLE cycle 3. Back-to-back throughput one write per 3 cycles minimum.
- DEC: AW+W handshake cycle 1, bvalid cycle 2 held until bready.
- No combinational path from m_awvalid to m_awready outside ADDR.

## Structure
- Package axil_xbar_pkg: state enum, RESP_OKAY=2'b00, RESP_DECERR=2'b11, clog2-derived index width helper.
- Sub-module axil_rr_arbiter (parameter N; req, advance, grant index, grant_valid); decode and routing inline.

## Test plan
- Single write M0 -> 0x1000_0004, data 0xDEAD_BEEF, strb 0xF -> S0 sees same addr/data/strb, bresp OKAY at M0, 3-cycle latency.
- M0..M3 awvalid simultaneously, all to S1 -> grant order 0,1,2,3; then M2 again with M0 -> order continues 3 ... (M0 before M2 after last grant 3).
- M1 write to 0x5000_0000 -> no slave valid asserted, M1 bresp 2'b11.
- W before AW by 4 cycles, and slave awready delayed 5 cycles -> single transfer, RESP entered only after both done.
- Master holds bready low 6 cycles -> bvalid held, no new grant; areset pulse mid-ADDR -> all outputs 0 next cycle, state IDLE.
